kernel_stage_buffer: RTL and testbench
======================================

# kernel_stage_buffer

Parametrised successor to the plain per-element feature/weight register stage. It buffers NDATA-element feature (if) and weight (w) vectors in a DEPTH-entry FIFO with valid/ready handshakes on both sides. It adds asynchronous reset, a synchronous flush, and a weight-reuse mode that lets upstream send a feature vector without re-sending weights. It sits between the operand fetch logic and the adder-kernel array and decouples fetch stalls from kernel consumption.

## Interface
- NBIT, default 8: bits per element.
- NDATA, default 9: elements per vector.
- DEPTH, default 2: FIFO entries; a power of 2, at least 2.
- CLK  in  1  clock; all state updates on the rising edge.
- RSTN  in  1  asynchronous, active-low reset.
- i_flush  in  1  synchronous clear of buffer contents.
- i_valid  in  1  upstream vector valid.
- o_ready  out  1  buffer can accept a vector.
- i_if  in  NBIT*NDATA  feature vector; element k is at [NBIT*k +: NBIT].
- i_w  in  NBIT*NDATA  weight vector, same packing; ignored when i_reuse=1.
- i_reuse  in  1  the entry uses the held weight instead of i_w.
- o_valid  out  1  head entry valid.
- i_ready  in  1  downstream accepts the head.
- o_if  out  NBIT*NDATA  head feature vector.
- o_w  out  NBIT*NDATA  head weight vector (stored or held).
- o_count  out  $clog2(DEPTH+1)  number of occupied entries.

## Operation
- Entry format: {if, w, reuse}.
- push = i_valid & o_ready. It writes {i_if, i_w, i_reuse} at wr_ptr and increments wr_ptr modulo DEPTH.
- pop = o_valid & i_ready. It increments rd_ptr modulo DEPTH.
- count update per cycle: +1 on push only, −1 on pop only, unchanged when both or neither.
- o_ready = (count != DEPTH). It depends only on registered state, with no combinational path from i_ready.
- o_valid = (count != 0).
- o_if = head.if when o_valid, otherwise all zeros.
- o_w when o_valid: head.reuse ? w_hold : head.w. When o_valid=0, o_w is all zeros.
- w_hold register:
  - On a pop of an entry with reuse=0, w_hold loads that entry's w.
  - On a pop of an entry with reuse=1, w_hold is unchanged.
  - Consecutive reuse entries therefore all see the weight of the most recent non-reuse entry popped before them.
- A reuse entry popped with no prior non-reuse pop since reset or flush outputs w_hold = 0. This is legal, not an error.
- i_flush=1:
  - Next state: count, wr_ptr, rd_ptr and w_hold all 0.
  - A push or pop attempted in the same cycle is discarded.
  - o_ready and o_valid still reflect pre-flush state during the flush cycle.
- Storage array is not reset. Its contents are invisible while empty because of the output gating.
- Arithmetic: no element is modified. Data passes bit-exact; only the weight-source select differs.

## Timing
- While RSTN=0, asynchronously: count=0, pointers=0, w_hold=0. Outputs: o_valid=0, o_ready=1, o_count=0, o_if=0, o_w=0.
- Latency: a vector pushed at edge k appears on o_if/o_w with o_valid=1 after edge k (one cycle). Nothing passes through combinationally.
- Throughput: one vector per cycle sustained when i_ready=1 continuously.
- Full (count=DEPTH): o_ready=0, so push is impossible.
  - A pop in that cycle makes o_ready=1 next cycle.
  - A full-buffer bubble is therefore possible only when downstream stalls.
- Empty: o_valid=0, and i_ready is ignored.
- Pointer wrap: DEPTH−1 → 0 with no lost entry. Required behaviour when exercised over ≥3·DEPTH pushes.
- Reset asserted mid-stream: all entries are dropped immediately. The first push after release is the next head.
- Handshake rule: once o_valid=1, o_if/o_w hold stable until a pop. Upstream may change i_if, i_w and i_reuse freely while o_ready=0.

## Test plan
- Reset, then push A (if elems 1..9, w elems 10..18, reuse=0) with i_ready=0 → after 1 edge: o_valid=1, o_if=A.if, o_w=A.w, o_count=1.
- DEPTH=2, i_ready=0, push 3 vectors back-to-back → o_ready=0 after the second push, the third is not accepted, o_count=2. Then i_ready=1 for 2 cycles → A then B pop in order, o_count=0.
- Push W (w=all 0x05, reuse=0), then P1, P2 (reuse=1, i_w=0xFF garbage), continuous pop → o_w=0x05 for all three, and o_if matches each vector.
- Continuous push/pop with i_ready=1 for 20 vectors (counter pattern), DEPTH=4 → output sequence identical, no bubbles after the first cycle, o_count ≤1 throughout.
- With count=2, assert i_flush together with i_valid=1 and i_ready=1 → next cycle o_count=0, o_valid=0, o_if=o_w=0. A subsequent reuse entry outputs o_w=0.
- Deassert RSTN asynchronously between edges while count=3 → o_valid=0, o_ready=1, o_count=0 immediately, before the next edge.

Source files
------------

// File: rtl/kernel_stage_buffer.sv
// kernel_stage_buffer: DEPTH-entry feature/weight FIFO in front of the adder kernels.
// Reuse entries take their weight from the most recent non-reuse entry popped.
module kernel_stage_buffer #(
    parameter int NBIT  = 8,
    parameter int NDATA = 9,
    parameter int DEPTH = 2
) (
    input  logic                       CLK,
    input  logic                       RSTN,
    input  logic                       i_flush,
    input  logic                       i_valid,
    output logic                       o_ready,
    input  logic [NBIT*NDATA-1:0]      i_if,
    input  logic [NBIT*NDATA-1:0]      i_w,
    input  logic                       i_reuse,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [NBIT*NDATA-1:0]      o_if,
    output logic [NBIT*NDATA-1:0]      o_w,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);
    localparam int VW = NBIT * NDATA;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [VW-1:0]    if_mem [DEPTH];
    logic [VW-1:0]    w_mem  [DEPTH];
    logic [DEPTH-1:0] reuse_mem;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [VW-1:0] w_hold;
    logic          push;
    logic          pop;

    assign o_ready = (count != FULL);
    assign o_valid = (count != '0);
    assign o_count = count;

    // A flush cycle swallows any handshake that coincides with it.
    assign push = i_valid & o_ready & ~i_flush;
    assign pop  = o_valid & i_ready & ~i_flush;

    always_ff @(posedge CLK) begin
        if (push) begin
            if_mem[wr_ptr]    <= i_if;
            w_mem[wr_ptr]     <= i_w;
            reuse_mem[wr_ptr] <= i_reuse;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            w_hold <= '0;
        end else if (i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            w_hold <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                if (!reuse_mem[rd_ptr]) begin
                    w_hold <= w_mem[rd_ptr];
                end
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    // Gating hides the unreset storage whenever the buffer is empty.
    always_comb begin
        o_if = '0;
        o_w  = '0;
        if (o_valid) begin
            o_if = if_mem[rd_ptr];
            o_w  = reuse_mem[rd_ptr] ? w_hold : w_mem[rd_ptr];
        end
    end

endmodule

// File: tb/tb_kernel_stage_buffer.sv
// Bench for kernel_stage_buffer: DEPTH=2 and DEPTH=4 instances on shared stimulus,
// checked every cycle against a queue model plus directed literal checks.
module tb_kernel_stage_buffer;
    localparam int VW = 72;

    logic          CLK = 1'b0;
    logic          RSTN = 1'b1;
    logic          i_flush = 1'b0;
    logic          i_valid = 1'b0;
    logic          i_reuse = 1'b0;
    logic          i_ready = 1'b0;
    logic [VW-1:0] i_if = '0;
    logic [VW-1:0] i_w = '0;

    logic          o_ready_a, o_valid_a;
    logic [VW-1:0] o_if_a, o_w_a;
    logic [1:0]    o_count_a;
    logic          o_ready_b, o_valid_b;
    logic [VW-1:0] o_if_b, o_w_b;
    logic [2:0]    o_count_b;

    int total = 0;
    int bad = 0;

    kernel_stage_buffer #(.NBIT(8), .NDATA(9), .DEPTH(2)) dut_a (
        .CLK(CLK), .RSTN(RSTN), .i_flush(i_flush), .i_valid(i_valid),
        .o_ready(o_ready_a), .i_if(i_if), .i_w(i_w), .i_reuse(i_reuse),
        .o_valid(o_valid_a), .i_ready(i_ready), .o_if(o_if_a), .o_w(o_w_a),
        .o_count(o_count_a)
    );

    kernel_stage_buffer #(.NBIT(8), .NDATA(9), .DEPTH(4)) dut_b (
        .CLK(CLK), .RSTN(RSTN), .i_flush(i_flush), .i_valid(i_valid),
        .o_ready(o_ready_b), .i_if(i_if), .i_w(i_w), .i_reuse(i_reuse),
        .o_valid(o_valid_b), .i_ready(i_ready), .o_if(o_if_b), .o_w(o_w_b),
        .o_count(o_count_b)
    );

    always #5 CLK = ~CLK;

    task automatic chk(string nm, logic [VW-1:0] act, logic [VW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    function automatic logic [VW-1:0] mk(int base);
        logic [VW-1:0] v;
        v = '0;
        for (int k = 0; k < 9; k++) v[8*k +: 8] = 8'(base + k);
        return v;
    endfunction

    // Model: per-instance ring of accepted vectors plus the held weight.
    typedef struct packed {
        logic [VW-1:0] f;
        logic [VW-1:0] w;
        logic          r;
    } ent_t;

    ent_t          mb [2][4];
    int            mhead [2];
    int            mcnt [2];
    logic [VW-1:0] mhold [2];
    int            dep [2] = '{2, 4};

    always @(posedge CLK or negedge RSTN) begin
        if (!RSTN || i_flush) begin
            for (int d = 0; d < 2; d++) begin
                mhead[d] = 0;
                mcnt[d]  = 0;
                mhold[d] = '0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                bit pu, po;
                int tail;
                pu   = i_valid && (mcnt[d] != dep[d]);
                po   = i_ready && (mcnt[d] != 0);
                tail = (mhead[d] + mcnt[d]) % dep[d];
                if (po) begin
                    if (!mb[d][mhead[d]].r) mhold[d] = mb[d][mhead[d]].w;
                    mhead[d] = (mhead[d] + 1) % dep[d];
                    mcnt[d]--;
                end
                if (pu) begin
                    mb[d][tail] = '{i_if, i_w, i_reuse};
                    mcnt[d]++;
                end
            end
        end
    end

    function automatic logic [VW-1:0] exp_if(int d);
        if (mcnt[d] == 0) return '0;
        return mb[d][mhead[d]].f;
    endfunction

    function automatic logic [VW-1:0] exp_w(int d);
        if (mcnt[d] == 0) return '0;
        return mb[d][mhead[d]].r ? mhold[d] : mb[d][mhead[d]].w;
    endfunction

    bit cmp_en = 1'b0;

    always @(negedge CLK) begin
        if (cmp_en) begin
            chk("a_valid", VW'(o_valid_a), VW'(mcnt[0] != 0));
            chk("a_ready", VW'(o_ready_a), VW'(mcnt[0] != 2));
            chk("a_count", VW'(o_count_a), VW'(mcnt[0]));
            chk("a_if", o_if_a, exp_if(0));
            chk("a_w", o_w_a, exp_w(0));
            chk("b_valid", VW'(o_valid_b), VW'(mcnt[1] != 0));
            chk("b_ready", VW'(o_ready_b), VW'(mcnt[1] != 4));
            chk("b_count", VW'(o_count_b), VW'(mcnt[1]));
            chk("b_if", o_if_b, exp_if(1));
            chk("b_w", o_w_b, exp_w(1));
        end
    end

    task automatic drive(bit v, logic [VW-1:0] f, logic [VW-1:0] w,
                         bit r, bit rdy, bit fl);
        i_valid = v;
        i_if    = f;
        i_w     = w;
        i_reuse = r;
        i_ready = rdy;
        i_flush = fl;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_pop();
        drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        logic [VW-1:0] all05;
        logic [VW-1:0] allff;
        all05 = {9{8'h05}};
        allff = {9{8'hFF}};

        #1 RSTN = 1'b0;
        @(posedge CLK);
        #1 cmp_en = 1'b1;
        @(posedge CLK);
        #1;
        chk("rst_valid", VW'(o_valid_b), VW'(0));
        chk("rst_ready", VW'(o_ready_b), VW'(1));
        chk("rst_count", VW'(o_count_b), VW'(0));
        chk("rst_if_w", o_if_b | o_w_b, '0);
        RSTN = 1'b1;

        // single push, then fill DEPTH=2 with a third offer refused
        drive(1'b1, mk(1), mk(10), 1'b0, 1'b0, 1'b0);
        chk("A_valid", VW'(o_valid_a), VW'(1));
        chk("A_if", o_if_a, mk(1));
        chk("A_w", o_w_a, mk(10));
        chk("A_count", VW'(o_count_a), VW'(1));
        drive(1'b1, mk(8'h31), mk(8'h41), 1'b0, 1'b0, 1'b0);
        chk("full_ready", VW'(o_ready_a), VW'(0));
        chk("full_count", VW'(o_count_a), VW'(2));
        drive(1'b1, mk(8'h51), mk(8'h61), 1'b0, 1'b0, 1'b0);
        chk("full_keep", VW'(o_count_a), VW'(2));
        chk("b_three", VW'(o_count_b), VW'(3));
        chk("full_head", o_if_a, mk(1));
        idle_pop();
        chk("popA_next", o_if_a, mk(8'h31));
        chk("popA_ready", VW'(o_ready_a), VW'(1));
        idle_pop();
        chk("popB_count", VW'(o_count_a), VW'(0));
        chk("b_C_head", o_if_b, mk(8'h51));
        idle_pop();

        // weight reuse
        drive(1'b1, mk(8'h20), all05, 1'b0, 1'b1, 1'b0);
        chk("W_w", o_w_a, all05);
        drive(1'b1, mk(8'h70), allff, 1'b1, 1'b1, 1'b0);
        chk("P1_w", o_w_a, all05);
        chk("P1_if", o_if_a, mk(8'h70));
        drive(1'b1, mk(8'h80), allff, 1'b1, 1'b1, 1'b0);
        chk("P2_w", o_w_b, all05);
        chk("P2_if", o_if_b, mk(8'h80));
        idle_pop();

        // sustained streaming
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, mk(i * 9), mk(200 - i), 1'b0, 1'b1, 1'b0);
            chk("stream_valid", VW'(o_valid_b), VW'(1));
            chk("stream_count", VW'(o_count_b), VW'(1));
            chk("stream_if", o_if_b, mk(i * 9));
        end
        idle_pop();

        // flush with simultaneous push and pop
        drive(1'b1, mk(8'h90), mk(8'hA0), 1'b0, 1'b0, 1'b0);
        drive(1'b1, mk(8'h94), mk(8'hA4), 1'b0, 1'b0, 1'b0);
        drive(1'b1, mk(8'h98), mk(8'hA8), 1'b0, 1'b1, 1'b1);
        chk("fl_count", VW'(o_count_a), VW'(0));
        chk("fl_valid", VW'(o_valid_b), VW'(0));
        chk("fl_out", o_if_a | o_w_a | o_if_b | o_w_b, '0);
        drive(1'b1, mk(8'hB0), allff, 1'b1, 1'b0, 1'b0);
        chk("fl_reuse_w", o_w_a, '0);
        chk("fl_reuse_if", o_if_b, mk(8'hB0));
        idle_pop();

        // mixed handshakes wrapping the pointers several times
        for (int i = 0; i < 40; i++) begin
            drive(i % 3 != 0, mk(i + 8'h10), mk(i + 8'h60), i % 5 == 0,
                  (i % 4) < 2, 1'b0);
        end
        repeat (4) idle_pop();

        // asynchronous reset mid-stream
        drive(1'b1, mk(8'h01), mk(8'h02), 1'b0, 1'b0, 1'b0);
        drive(1'b1, mk(8'h03), mk(8'h04), 1'b0, 1'b0, 1'b0);
        drive(1'b1, mk(8'h05), mk(8'h06), 1'b0, 1'b0, 1'b0);
        chk("pre_rst", VW'(o_count_b), VW'(3));
        #2 RSTN = 1'b0;
        #1;
        chk("arst_valid", VW'(o_valid_b), VW'(0));
        chk("arst_ready", VW'(o_ready_b), VW'(1));
        chk("arst_count", VW'(o_count_b), VW'(0));
        chk("arst_a", VW'(o_count_a), VW'(0));
        i_valid = 1'b0;
        @(posedge CLK);
        #1 RSTN = 1'b1;
        drive(1'b1, mk(8'hC0), mk(8'hD0), 1'b0, 1'b0, 1'b0);
        chk("post_rst_cnt", VW'(o_count_b), VW'(1));
        chk("post_rst_if", o_if_b, mk(8'hC0));
        chk("post_rst_w", o_w_a, mk(8'hD0));
        repeat (2) idle_pop();

        @(negedge CLK);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
